// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/done handshake bundle for the bit-serial subtractor
// Purpose: groups the request (start, a, b) and response (busy, done, diff,
//          borrow_out, overflow) signals of serial_sub.
// Ports:   master drives start/a/b and observes the result;
//          slave (the subtractor) receives start/a/b and drives the result.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial two's-complement subtractor, LSB first
// Purpose: diff = a - b mod 2^WIDTH computed one bit per clock with a single
//          borrow flip-flop; operands captured on start, result held until the
//          next completion.
// Ports:   clk  - rising-edge clock
//          rst  - synchronous reset, active-high
//          bus  - serial_sub_if.slave: start, a, b in; busy, done, diff,
//                 borrow_out, overflow out
// Option:  SERIAL_SUB_OVF_EN - when defined, overflow reports signed overflow;
//          otherwise overflow is constant 0.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] rr;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;

  logic             d;
  logic             bw_next;
  logic             last;
  logic [WIDTH-1:0] rr_next;

  always_comb begin
    d       = sa[0] ^ sb[0] ^ bw;
    bw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    rr_next = rr >> 1;
    rr_next[WIDTH-1] = d;
    last    = (cnt == CW'(WIDTH - 1));
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  logic ovf_next;
  // Only meaningful on the last bit, where sa[0]/sb[0] are the sign bits.
  assign ovf_next     = (sa[0] ^ sb[0]) & (sa[0] ^ d);
  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      rr       <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      bw       <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE for back-to-back use.
        IDLE, DONE: begin
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            rr     <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          rr  <= rr_next;
          bw  <= bw_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= rr_next;
            borrow_q <= bw_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_next;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
